trig_terms_sequencer: RTL and testbench

- Sequential producer of the trigonometric product terms consumed by the arm position calculator: l1sin2, l2sin23, l34sin234, their cosine counterparts, and sin1/cos1 of the spin angle.
- Computes all four sin/cos pairs with one shared iterative CORDIC engine and one shared Q1.17 multiplier, under a start/done handshake.
- Outputs are registered and held stable between jobs, so the downstream stage can sample them continuously.

---
 rtl/trig_terms_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_trig_terms_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_terms_sequencer.sv
// Sequential producer of the arm-geometry trig terms: one iterative CORDIC engine
// and one Q1.17 multiplier are time-shared over the four job angles.
module trig_terms_sequencer #(
   parameter int ITERS = 16
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [17:0] spin_angle_i,
   input  logic [17:0] shoulder_angle_i,
   input  logic [17:0] elbow_angle_i,
   input  logic [17:0] wrist_angle_i,
   input  logic [17:0] bicep_len_i,
   input  logic [17:0] forearm_len_i,
   input  logic [17:0] wrist_len_i,
   input  logic [17:0] finger_len_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [17:0] l1sin2_o,
   output logic [17:0] l2sin23_o,
   output logic [17:0] l34sin234_o,
   output logic [17:0] l1cos2_o,
   output logic [17:0] l2cos23_o,
   output logic [17:0] l34cos234_o,
   output logic [17:0] sin1_o,
   output logic [17:0] cos1_o
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PREP, S_ROT, S_POST, S_DONE} state_t;

   localparam logic [4:0] IT_LAST = 5'(ITERS - 1);
   // x/y keep 3 guard bits below Q1.17; z keeps 4 guard bits below the 2^18-per-turn unit.
   localparam logic signed [23:0] X_SEED  = 24'sd636752;
   localparam logic signed [23:0] SAT_MAX = 24'sd131071;

   state_t             state_q, state_d;
   logic [1:0]         k_q, k_d;
   logic [4:0]         it_q, it_d;
   logic               accept;

   logic [17:0]        ang_q [4];
   logic [17:0]        len_q [3];
   logic signed [23:0] x_q, y_q, z_q;
   logic               neg_q;
   logic signed [17:0] psin_q [3];
   logic signed [17:0] pcos_q [3];
   logic signed [17:0] cos_pend_q;
   logic [17:0]        out_q [8];

   logic [17:0]        ang_sel;
   logic signed [23:0] x_sh, y_sh, at_i, x_n, y_n;
   logic signed [17:0] sin_sat, cos_sat, mul_a, mul_res;
   logic [17:0]        mul_len;
   logic signed [36:0] prod;

   function automatic logic signed [23:0] atan_lut(input logic [4:0] i);
      case (i)
         5'd0:    return 24'sd524288;
         5'd1:    return 24'sd309505;
         5'd2:    return 24'sd163534;
         5'd3:    return 24'sd83012;
         5'd4:    return 24'sd41667;
         5'd5:    return 24'sd20854;
         5'd6:    return 24'sd10430;
         5'd7:    return 24'sd5215;
         5'd8:    return 24'sd2608;
         5'd9:    return 24'sd1304;
         5'd10:   return 24'sd652;
         5'd11:   return 24'sd326;
         5'd12:   return 24'sd163;
         5'd13:   return 24'sd81;
         5'd14:   return 24'sd41;
         5'd15:   return 24'sd20;
         5'd16:   return 24'sd10;
         default: return 24'sd0;
      endcase
   endfunction

   function automatic logic signed [17:0] sat18(input logic signed [23:0] v);
      if (v > SAT_MAX)  return 18'sd131071;
      if (v < -SAT_MAX) return -18'sd131071;
      return v[17:0];
   endfunction

   assign accept = start_i && (state_q == S_IDLE || state_q == S_DONE);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      k_d     = k_q;
      it_d    = it_q;
      unique case (state_q)
         S_IDLE: if (start_i) state_d = S_LOAD;
         S_LOAD: begin
            state_d = S_PREP;
            k_d     = 2'd0;
         end
         S_PREP: begin
            state_d = S_ROT;
            it_d    = 5'd0;
         end
         S_ROT: begin
            if (it_q == IT_LAST) state_d = S_POST;
            else                 it_d    = it_q + 5'd1;
         end
         S_POST: begin
            if (k_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               state_d = S_PREP;
               k_d     = k_q + 2'd1;
            end
         end
         S_DONE:  state_d = start_i ? S_LOAD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         k_q     <= 2'd0;
         it_q    <= 5'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         it_q    <= it_d;
      end
   end

   always_comb begin
      ang_sel = ang_q[k_q];
      x_sh    = x_q >>> it_q;
      y_sh    = y_q >>> it_q;
      at_i    = atan_lut(it_q);
      x_n     = neg_q ? -x_q : x_q;
      y_n     = neg_q ? -y_q : y_q;
      cos_sat = sat18((x_n + 24'sd4) >>> 3);
      sin_sat = sat18((y_n + 24'sd4) >>> 3);
   end

   // The multiplier forms the sine product in POST_k and the deferred cosine
   // product of angle k-1 in PREP_k, so one multiplier covers both terms.
   always_comb begin
      mul_a   = sin_sat;
      mul_len = len_q[0];
      if (state_q == S_PREP) begin
         mul_a = cos_pend_q;
         case (k_q)
            2'd2:    mul_len = len_q[1];
            2'd3:    mul_len = len_q[2];
            default: mul_len = len_q[0];
         endcase
      end else begin
         case (k_q)
            2'd1:    mul_len = len_q[1];
            2'd2:    mul_len = len_q[2];
            default: mul_len = len_q[0];
         endcase
      end
      prod    = 37'(signed'({1'b0, mul_len})) * 37'(mul_a);
      mul_res = 18'(prod >>> 17);
   end

   // NOTE: job and datapath registers carry no reset; each is written before it is read in every job.
   always_ff @(posedge clock_i) begin
      if (accept) begin
         ang_q[0] <= shoulder_angle_i;
         ang_q[1] <= shoulder_angle_i + elbow_angle_i;
         ang_q[2] <= shoulder_angle_i + elbow_angle_i + wrist_angle_i;
         ang_q[3] <= spin_angle_i;
         len_q[0] <= bicep_len_i;
         len_q[1] <= forearm_len_i;
         len_q[2] <= wrist_len_i + finger_len_i;
      end
      case (state_q)
         S_PREP: begin
            // Quadrants 01/10 rotate by half a turn: flip bit 17, negate at the end.
            x_q   <= X_SEED;
            y_q   <= '0;
            z_q   <= {{3{ang_sel[16]}}, ang_sel[16:0], 4'b0000};
            neg_q <= ang_sel[17] ^ ang_sel[16];
            if (k_q != 2'd0) pcos_q[k_q - 2'd1] <= mul_res;
         end
         S_ROT: begin
            if (!z_q[23]) begin
               x_q <= x_q - y_sh;
               y_q <= y_q + x_sh;
               z_q <= z_q - at_i;
            end else begin
               x_q <= x_q + y_sh;
               y_q <= y_q - x_sh;
               z_q <= z_q + at_i;
            end
         end
         S_POST: begin
            if (k_q != 2'd3) begin
               psin_q[k_q] <= mul_res;
               cos_pend_q  <= cos_sat;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         for (int j = 0; j < 8; j++) out_q[j] <= '0;
      end else if (state_q == S_POST && k_q == 2'd3) begin
         out_q[0] <= psin_q[0];
         out_q[1] <= psin_q[1];
         out_q[2] <= psin_q[2];
         out_q[3] <= pcos_q[0];
         out_q[4] <= pcos_q[1];
         out_q[5] <= pcos_q[2];
         out_q[6] <= sin_sat;
         out_q[7] <= cos_sat;
      end
   end

   assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o      = (state_q == S_DONE);
   assign l1sin2_o    = out_q[0];
   assign l2sin23_o   = out_q[1];
   assign l34sin234_o = out_q[2];
   assign l1cos2_o    = out_q[3];
   assign l2cos23_o   = out_q[4];
   assign l34cos234_o = out_q[5];
   assign sin1_o      = out_q[6];
   assign cos1_o      = out_q[7];

endmodule

// File: tb/tb_trig_terms_sequencer.sv
// Self-checking bench for trig_terms_sequencer: real-valued trig model, timing and handshake checks.
module tb_trig_terms_sequencer;

   localparam int LAT = 74;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [17:0] spin_angle = '0, shoulder_angle = '0, elbow_angle = '0, wrist_angle = '0;
   logic [17:0] bicep_len = '0, forearm_len = '0, wrist_len = '0, finger_len = '0;
   logic        busy, done;
   logic [17:0] l1sin2, l2sin23, l34sin234, l1cos2, l2cos23, l34cos234, sin1, cos1;

   int    total = 0;
   int    bad = 0;
   real   ideal [8];
   string names [8] = '{"l1sin2", "l2sin23", "l34sin234", "l1cos2", "l2cos23", "l34cos234", "sin1", "cos1"};
   logic signed [17:0] got [8];

   assign got[0] = l1sin2;
   assign got[1] = l2sin23;
   assign got[2] = l34sin234;
   assign got[3] = l1cos2;
   assign got[4] = l2cos23;
   assign got[5] = l34cos234;
   assign got[6] = sin1;
   assign got[7] = cos1;

   trig_terms_sequencer #(.ITERS(16)) dut (
      .clock_i(clk), .reset_i(rst_n), .start_i(start),
      .spin_angle_i(spin_angle), .shoulder_angle_i(shoulder_angle),
      .elbow_angle_i(elbow_angle), .wrist_angle_i(wrist_angle),
      .bicep_len_i(bicep_len), .forearm_len_i(forearm_len),
      .wrist_len_i(wrist_len), .finger_len_i(finger_len),
      .busy_o(busy), .done_o(done),
      .l1sin2_o(l1sin2), .l2sin23_o(l2sin23), .l34sin234_o(l34sin234),
      .l1cos2_o(l1cos2), .l2cos23_o(l2cos23), .l34cos234_o(l34cos234),
      .sin1_o(sin1), .cos1_o(cos1)
   );

   always #5 clk = ~clk;

   function automatic int trig_q(input real v);
      int q;
      q = int'(v * 131072.0);
      if (q > 131071)  q = 131071;
      if (q < -131071) q = -131071;
      return q;
   endfunction

   // Ideal values straight from the geometry: angles in turns, lengths as integers.
   task automatic model_job(input int spin_v, sh, el, wr, bl, fl, wl, fgl);
      real th;
      int  a [4];
      int  l [3];
      a[0] = sh;
      a[1] = (sh + el) % 262144;
      a[2] = (sh + el + wr) % 262144;
      a[3] = spin_v;
      l[0] = bl;
      l[1] = fl;
      l[2] = wl + fgl;
      for (int k = 0; k < 3; k++) begin
         th = 6.283185307179586 * real'(a[k]) / 262144.0;
         ideal[k]     = real'(l[k]) * $sin(th);
         ideal[k + 3] = real'(l[k]) * $cos(th);
      end
      th = 6.283185307179586 * real'(a[3]) / 262144.0;
      ideal[6] = real'(trig_q($sin(th)));
      ideal[7] = real'(trig_q($cos(th)));
   endtask

   task automatic apply_job(input int spin_v, sh, el, wr, bl, fl, wl, fgl);
      spin_angle     = 18'(spin_v);
      shoulder_angle = 18'(sh);
      elbow_angle    = 18'(el);
      wrist_angle    = 18'(wr);
      bicep_len      = 18'(bl);
      forearm_len    = 18'(fl);
      wrist_len      = 18'(wl);
      finger_len     = 18'(fgl);
      model_job(spin_v, sh, el, wr, bl, fl, wl, fgl);
   endtask

   // Called just before the accepting edge with start high; cycle n is the n-th
   // period after that edge, sampled on its falling edge.
   task automatic wait_done(input int pulse_at, input bit hold,
                            output int done_cyc, output int busy_errs, output int extra);
      done_cyc  = -1;
      busy_errs = 0;
      extra     = 0;
      for (int n = 1; n <= LAT + 20 && done_cyc < 0; n++) begin
         @(negedge clk);
         if (done) begin
            done_cyc = n;
            if (busy) busy_errs++;
         end else if (!busy) begin
            busy_errs++;
         end
         if (n == pulse_at) begin
            start          = 1'b1;
            shoulder_angle = 18'($urandom);
            spin_angle     = 18'($urandom);
            bicep_len      = 18'($urandom_range(0, 65535));
         end else if (!hold) begin
            start = 1'b0;
         end
      end
      if (!hold && done_cyc > 0) begin
         repeat (3) begin
            @(negedge clk);
            if (done) extra++;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (got[j] !== 18'sd0) begin bad++; $display("FAIL reset %s: got %0d want 0", names[j], got[j]); end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_directed(input string tag, input int spin_v, sh, el, wr, bl, fl, wl, fgl);
      int dc, be, ex;
      @(negedge clk);
      apply_job(spin_v, sh, el, wr, bl, fl, wl, fgl);
      start = 1'b1;
      wait_done(0, 1'b0, dc, be, ex);
      total++;
      if (dc !== LAT) begin bad++; $display("FAIL %s latency: got %0d want %0d", tag, dc, LAT); end
      total++;
      if (be !== 0 || ex !== 0) begin bad++; $display("FAIL %s busy/done: busy_errs %0d extra_done %0d want 0 0", tag, be, ex); end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (real'(got[j]) - ideal[j] > 4.0 || ideal[j] - real'(got[j]) > 4.0) begin
            bad++; $display("FAIL %s %s: got %0d want %0.2f +/-4", tag, names[j], got[j], ideal[j]);
         end
      end
   endtask

   task automatic test_zero_angles();
      run_directed("zero_angles", 0, 0, 0, 0, 1000, 2000, 300, 200);
   endtask

   task automatic test_quadrant();
      run_directed("quadrant", 32768, 65536, 0, 0, 1000, 2000, 300, 200);
   endtask

   task automatic test_wrap();
      run_directed("wrap", 'h20000, 'h30000, 'h20000, 0, 1000, 2000, 300, 200);
   endtask

   task automatic test_boundaries();
      run_directed("edge_a", 'h3FFFF, 'h0FFFF, 1, 'h10000, 65535, 65535, 65535, 65535);
      run_directed("edge_b", 'h1FFFF, 'h2FFFF, 'h10001, 'h3FFFF, 1, 65535, 0, 1);
   endtask

   task automatic test_ignored_start();
      int dc, be, ex;
      @(negedge clk);
      apply_job(12345, 40000, 70000, 150000, 777, 4321, 1000, 23456);
      start = 1'b1;
      wait_done(10, 1'b0, dc, be, ex);
      total++;
      if (dc !== LAT) begin bad++; $display("FAIL ignored_start latency: got %0d want %0d", dc, LAT); end
      total++;
      if (be !== 0) begin bad++; $display("FAIL ignored_start busy: errs %0d want 0", be); end
      total++;
      if (ex !== 0) begin bad++; $display("FAIL ignored_start extra done: got %0d want 0", ex); end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (real'(got[j]) - ideal[j] > 4.0 || ideal[j] - real'(got[j]) > 4.0) begin
            bad++; $display("FAIL ignored_start %s: got %0d want %0.2f +/-4", names[j], got[j], ideal[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int dc, be, ex;
      @(negedge clk);
      apply_job(200000, 10000, 20000, 30000, 5000, 6000, 7000, 8000);
      start = 1'b1;
      wait_done(0, 1'b1, dc, be, ex);
      total++;
      if (dc !== LAT || be !== 0) begin bad++; $display("FAIL b2b first: done_cyc %0d busy_errs %0d want %0d 0", dc, be, LAT); end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (real'(got[j]) - ideal[j] > 4.0 || ideal[j] - real'(got[j]) > 4.0) begin
            bad++; $display("FAIL b2b first %s: got %0d want %0.2f +/-4", names[j], got[j], ideal[j]);
         end
      end
      apply_job(99999, 250000, 123456, 65536, 65000, 1, 32000, 33000);
      wait_done(0, 1'b0, dc, be, ex);
      total++;
      if (dc !== LAT || be !== 0 || ex !== 0) begin
         bad++; $display("FAIL b2b second: done_cyc %0d busy_errs %0d extra %0d want %0d 0 0", dc, be, ex, LAT);
      end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (real'(got[j]) - ideal[j] > 4.0 || ideal[j] - real'(got[j]) > 4.0) begin
            bad++; $display("FAIL b2b second %s: got %0d want %0.2f +/-4", names[j], got[j], ideal[j]);
         end
      end
   endtask

   task automatic test_reset_abort();
      int ndone;
      @(negedge clk);
      apply_job(5000, 6000, 7000, 8000, 900, 800, 700, 600);
      start = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort busy/done: got %b/%b want 0/0", busy, done); end
      for (int j = 0; j < 8; j++) begin
         total++;
         if (got[j] !== 18'sd0) begin bad++; $display("FAIL abort %s: got %0d want 0", names[j], got[j]); end
      end
      rst_n = 1'b1;
      ndone = 0;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (done) ndone++;
      end
      total++;
      if (ndone !== 0) begin bad++; $display("FAIL abort stray done: got %0d want 0", ndone); end
      run_directed("after_abort", 5000, 6000, 7000, 8000, 900, 800, 700, 600);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         run_directed("random",
                      int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                      int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                      int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      end
   endtask

   initial begin
      test_reset();
      test_zero_angles();
      test_quadrant();
      test_wrap();
      test_boundaries();
      test_ignored_start();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
